// File: rtl/ntcrack_multilane_ctrl.sv
// Multi-lane cracking sequencer: hash load, fill/run/check batches
// over LANES md4 lanes, with a match FIFO drained byte-wise by the host.
module ntcrack_multilane_ctrl #(
  parameter int LANES       = 4,
  parameter int MAX_PW_LEN  = 20,
  parameter int MATCH_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    new_hash_byte,
  input  logic                          store_hash_byte,
  input  logic                          go,
  input  logic                          stop,
  output logic                          your_turn,
  output logic                          busy,
  output logic                          match_found,
  output logic [7:0]                    password_byte,
  input  logic                          match_ack,
  output logic                          inc_trigger,
  input  logic                          inc_done,
  input  logic [8*MAX_PW_LEN-1:0]       inc_chars,
  input  logic [4:0]                    inc_len,
  input  logic                          inc_exhausted,
  output logic [LANES-1:0]              lane_irdy,
  output logic [8*MAX_PW_LEN*LANES-1:0] lane_chars,
  output logic [5*LANES-1:0]            lane_len,
  input  logic [LANES-1:0]              lane_ordy,
  input  logic [128*LANES-1:0]          lane_hash,
  output logic                          chk_newrdy,
  output logic                          chk_checkrdy,
  output logic [127:0]                  chk_hash,
  input  logic                          chk_resultrdy,
  input  logic                          chk_matchfound
);

  localparam int CW  = 8 * MAX_PW_LEN;
  localparam int EW  = CW + 5;
  localparam int AW  = $clog2(MATCH_DEPTH);
  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_HGAP, S_HNEW, S_HWAIT,
    S_FTRIG, S_FWAIT, S_RUN, S_RWAIT,
    S_CSEL, S_CREQ, S_CWAIT, S_CPUSH
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           hidx_q, hidx_d;
  logic [LIW-1:0]       lane_q, lane_d;
  logic [LANES-1:0]     valid_q, valid_d;
  logic                 exh_q, exh_d;
  logic [127:0]         hash_q, hash_d;
  logic [CW*LANES-1:0]  chars_q, chars_d;
  logic [5*LANES-1:0]   len_q, len_d;

  logic [EW-1:0]        mem_q [MATCH_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic [4:0]           bcnt_q, bcnt_d;

  logic                 push, pop, empty, full;
  logic                 ack_ok, last_b;
  logic                 adv, finish;
  logic                 lane_last;
  logic [EW-1:0]        push_data;
  logic [EW-1:0]        head;
  logic [CW-1:0]        head_chars;
  logic [4:0]           bsel, offs;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign last_b = (bcnt_q == 5'(MAX_PW_LEN));
  assign ack_ok = match_ack && !empty;
  assign pop    = ack_ok && last_b;
  assign lane_last = (lane_q == LIW'(LANES - 1));

  assign push_data = {chars_q[CW*lane_q +: CW], len_q[5*lane_q +: 5]};

  assign head       = mem_q[rd_q[AW-1:0]];
  assign head_chars = head[EW-1:5];
  assign bsel       = last_b ? 5'd0 : bcnt_q;
  assign offs       = 5'(MAX_PW_LEN - 1) - bsel;

  // Readout byte: chars MSB-first, then the length byte
  always_comb begin
    password_byte = 8'h00;
    if (!empty) begin
      if (last_b) password_byte = {3'b000, head[4:0]};
      else        password_byte = head_chars[8*offs +: 8];
    end
  end

  assign match_found  = !empty;
  assign your_turn    = (state_q == S_IDLE);
  assign busy         = !(state_q == S_IDLE || state_q == S_HGAP ||
                          state_q == S_HNEW || state_q == S_HWAIT);
  assign inc_trigger  = (state_q == S_FTRIG);
  assign lane_irdy    = (state_q == S_RUN) ? valid_q : '0;
  assign chk_newrdy   = (state_q == S_HNEW);
  assign chk_checkrdy = (state_q == S_CREQ);
  assign chk_hash     = hash_q;
  assign lane_chars   = chars_q;
  assign lane_len     = len_q;

  // Main sequencer next-state and datapath updates
  always_comb begin
    state_d = state_q;
    hidx_d  = hidx_q;
    lane_d  = lane_q;
    valid_d = valid_q;
    exh_d   = exh_q;
    hash_d  = hash_q;
    chars_d = chars_q;
    len_d   = len_q;
    push    = 1'b0;
    adv     = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_FTRIG;
          lane_d  = '0;
          valid_d = '0;
          exh_d   = 1'b0;
        end else if (store_hash_byte) begin
          hash_d[8*(4'd15 - hidx_q) +: 8] = new_hash_byte;
          if (hidx_q == 4'd15) begin
            hidx_d  = 4'd0;
            state_d = S_HNEW;
          end else begin
            hidx_d  = hidx_q + 4'd1;
            state_d = S_HGAP;
          end
        end
      end
      S_HGAP:  state_d = S_IDLE;
      S_HNEW:  state_d = S_HWAIT;
      S_HWAIT: if (chk_resultrdy) state_d = S_IDLE;
      S_FTRIG: state_d = S_FWAIT;
      S_FWAIT: begin
        if (inc_done) begin
          if (inc_exhausted) begin
            exh_d   = 1'b1;
            state_d = S_RUN;
          end else begin
            chars_d[CW*lane_q +: CW] = inc_chars;
            len_d[5*lane_q +: 5]     = inc_len;
            valid_d[lane_q]          = 1'b1;
            if (lane_last) begin
              state_d = S_RUN;
            end else begin
              lane_d  = lane_q + 1'b1;
              state_d = S_FTRIG;
            end
          end
        end
      end
      S_RUN:   state_d = S_RWAIT;
      S_RWAIT: begin
        if ((lane_ordy & valid_q) == valid_q) begin
          lane_d  = '0;
          state_d = S_CSEL;
        end
      end
      S_CSEL: begin
        if (!valid_q[lane_q]) begin
          finish = 1'b1;
        end else begin
          hash_d  = lane_hash[128*lane_q +: 128];
          state_d = S_CREQ;
        end
      end
      S_CREQ:  state_d = S_CWAIT;
      S_CWAIT: begin
        if (chk_resultrdy) begin
          if (chk_matchfound) state_d = S_CPUSH;
          else                adv = 1'b1;
        end
      end
      S_CPUSH: begin
        if (!full || pop) begin
          push = 1'b1;
          adv  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (lane_last) begin
        finish = 1'b1;
      end else begin
        lane_d  = lane_q + 1'b1;
        state_d = S_CSEL;
      end
    end
    if (finish) begin
      lane_d = '0;
      if (exh_q || stop) begin
        state_d = S_IDLE;
      end else begin
        valid_d = '0;
        state_d = S_FTRIG;
      end
    end
  end

  // Readout byte counter advance on accepted acks
  always_comb begin
    bcnt_d = bcnt_q;
    if (ack_ok) bcnt_d = last_b ? 5'd0 : bcnt_q + 5'd1;
  end

  // Sequencer, lane and FIFO pointer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hidx_q  <= '0;
      lane_q  <= '0;
      valid_q <= '0;
      exh_q   <= 1'b0;
      hash_q  <= '0;
      chars_q <= {(MAX_PW_LEN*LANES){8'h20}};
      len_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hidx_q  <= hidx_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      exh_q   <= exh_d;
      hash_q  <= hash_d;
      chars_q <= chars_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Match FIFO storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule
